// File: rtl/lcd_cmd_seq.sv
// ----------------------------------------------------------------------------
// lcd_cmd_seq
//
// Controller for the 32-entry LCD command register bank. It owns the bank's
// write side (sel_in plus a held 24-bit command word on ctrl_out) and its read
// side (sel_out). It replays the stored command list to the LCD interface
// engine one entry at a time, using a lcd_start/lcd_done handshake, an idle gap
// after each command and a per-command timeout.
//
// Parameters:
//   GAP_CYCLES     idle clocks after each completed command (0 = no gap)
//   TIMEOUT_CYCLES clocks to wait for lcd_done before aborting (16-bit counter)
//
// Ports:
//   clk, reset   system clock, asynchronous active-high reset
//   host_we      one-cycle request to append host_data to the list
//   host_data    command word {addr[23:16], ctrl[15:8], data[7:0]}
//   host_clear   one-cycle request to empty the list (ignored while running)
//   host_start   one-cycle request to replay entries 0..cmd_count-1
//   host_ack     one-cycle pulse, write accepted
//   cmd_count    number of stored commands, 0..32
//   full         cmd_count == 32
//   overflow     sticky, a write was dropped because the list was full
//   running      sequencer is not idle
//   seq_done     one-cycle pulse, sequence finished or aborted
//   timeout_err  sticky, last sequence aborted on timeout
//   ctrl_out     command word driven to the bank's ctrl_in
//   sel_in       bank write index
//   sel_out      bank read index
//   lcd_start    one-cycle strobe to the LCD engine, bank outputs valid
//   lcd_done     one-cycle pulse from the LCD engine, command completed
// ----------------------------------------------------------------------------
module lcd_cmd_seq #(
    parameter int GAP_CYCLES     = 50,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        host_we,
    input  logic [23:0] host_data,
    input  logic        host_clear,
    input  logic        host_start,
    output logic        host_ack,
    output logic [5:0]  cmd_count,
    output logic        full,
    output logic        overflow,
    output logic        running,
    output logic        seq_done,
    output logic        timeout_err,
    output logic [23:0] ctrl_out,
    output logic [4:0]  sel_in,
    output logic [4:0]  sel_out,
    output logic        lcd_start,
    input  logic        lcd_done
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] GAP_LAST     = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;
    localparam bit          HAS_GAP      = (GAP_CYCLES > 0);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STROBE,
        WAIT,
        GAP,
        NEXT
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [5:0]  idx;
    logic [15:0] cnt;

    logic write_ok;
    logic write_full;
    logic clear_ok;
    logic start_ok;
    logic start_run;
    logic done_seen;
    logic time_up;
    logic gap_end;
    logic last_cmd;
    logic lcd_start_nxt;
    logic seq_done_nxt;

    assign full    = (cmd_count == 6'd32);
    assign running = (state != IDLE);

    // State register; reset drops the sequencer straight back to IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. One cycle in LOAD gives the bank time to register
    // its outputs for the freshly changed sel_out before the strobe.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_run) begin
                    state_nxt = LOAD;
                end
            end
            LOAD:   state_nxt = STROBE;
            STROBE: state_nxt = WAIT;
            WAIT: begin
                if (lcd_done) begin
                    state_nxt = HAS_GAP ? GAP : NEXT;
                end else if (time_up) begin
                    state_nxt = IDLE;
                end
            end
            GAP: begin
                if (gap_end) begin
                    state_nxt = NEXT;
                end
            end
            NEXT: begin
                state_nxt = last_cmd ? IDLE : LOAD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output/decision logic. Host writes and clears are only honoured while
    // idle; a clear in the same cycle as a write wins and drops the write.
    always_comb begin
        write_ok      = host_we && (state == IDLE) && !full && !host_clear;
        write_full    = host_we && (state == IDLE) && full && !host_clear;
        clear_ok      = host_clear && (state == IDLE);
        start_ok      = host_start && (state == IDLE);
        start_run     = start_ok && (cmd_count != 6'd0);
        done_seen     = (state == WAIT) && lcd_done;
        time_up       = (state == WAIT) && !lcd_done && (cnt == TIMEOUT_LAST);
        gap_end       = (state == GAP) && (cnt == GAP_LAST);
        last_cmd      = (state == NEXT) && (idx == cmd_count);
        lcd_start_nxt = (state == STROBE);
        seq_done_nxt  = (start_ok && (cmd_count == 6'd0)) || time_up || last_cmd;
    end

    // Write side of the bank. The bank rewrites entry sel_in every clock, so
    // sel_in and ctrl_out move together and otherwise hold; a clear leaves
    // them alone so the last stored entry keeps its value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            host_ack  <= 1'b0;
            ctrl_out  <= 24'd0;
            sel_in    <= 5'd0;
            cmd_count <= 6'd0;
            overflow  <= 1'b0;
        end else begin
            host_ack <= write_ok;
            if (clear_ok) begin
                cmd_count <= 6'd0;
                overflow  <= 1'b0;
            end else if (write_ok) begin
                ctrl_out  <= host_data;
                sel_in    <= cmd_count[4:0];
                cmd_count <= cmd_count + 6'd1;
            end else if (write_full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Read side and handshake registers. idx is one bit wider than sel_out so
    // that a full list of 32 can be detected as idx == cmd_count; sel_out only
    // ever takes indices that are still to be replayed, so it holds the last
    // entry read once the sequence ends.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx         <= 6'd0;
            sel_out     <= 5'd0;
            lcd_start   <= 1'b0;
            seq_done    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            lcd_start <= lcd_start_nxt;
            seq_done  <= seq_done_nxt;
            if (start_ok) begin
                timeout_err <= 1'b0;
            end else if (time_up) begin
                timeout_err <= 1'b1;
            end
            if (start_run) begin
                idx     <= 6'd0;
                sel_out <= 5'd0;
            end else if (done_seen) begin
                idx <= idx + 6'd1;
            end else if ((state == NEXT) && !last_cmd) begin
                sel_out <= idx[4:0];
            end
        end
    end

    // Shared counter: measures the wait for lcd_done, then the inter-command
    // gap. It restarts on the strobe and again when the command completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= 16'd0;
        end else if (state == STROBE) begin
            cnt <= 16'd0;
        end else if (state == WAIT) begin
            cnt <= lcd_done ? 16'd0 : cnt + 16'd1;
        end else if (state == GAP) begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// ----------------------------------------------------------------------------
// tb_lcd_cmd_seq
//
// Self-checking bench for lcd_cmd_seq. A queue holds the command list as the
// host sees it; a small register-bank model follows sel_in/ctrl_out/sel_out so
// the word presented at each lcd_start can be compared with the queue.
// Expected timing is derived from the handshake rules: first strobe three
// clocks after host_start, each next strobe d + GAP + 4 clocks after the
// previous one (d = clocks until lcd_done), seq_done d + GAP + 2 clocks after
// the last strobe, and a timeout abort TIMEOUT clocks after the strobe.
// ----------------------------------------------------------------------------
module tb_lcd_cmd_seq;

    localparam int GAP = 2;
    localparam int TO  = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        host_we;
    logic [23:0] host_data;
    logic        host_clear;
    logic        host_start;
    logic        host_ack;
    logic [5:0]  cmd_count;
    logic        full;
    logic        overflow;
    logic        running;
    logic        seq_done;
    logic        timeout_err;
    logic [23:0] ctrl_out;
    logic [4:0]  sel_in;
    logic [4:0]  sel_out;
    logic        lcd_start;
    logic        lcd_done;

    int checks = 0;
    int errors = 0;

    logic [23:0] model_list[$];
    bit          model_ovf;

    logic [23:0] bank [32];
    logic [23:0] bank_q;

    lcd_cmd_seq #(
        .GAP_CYCLES    (GAP),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .host_we    (host_we),
        .host_data  (host_data),
        .host_clear (host_clear),
        .host_start (host_start),
        .host_ack   (host_ack),
        .cmd_count  (cmd_count),
        .full       (full),
        .overflow   (overflow),
        .running    (running),
        .seq_done   (seq_done),
        .timeout_err(timeout_err),
        .ctrl_out   (ctrl_out),
        .sel_in     (sel_in),
        .sel_out    (sel_out),
        .lcd_start  (lcd_start),
        .lcd_done   (lcd_done)
    );

    always #5 clk = ~clk;

    // Register bank: rewrites entry sel_in every clock, registered read port.
    always @(posedge clk) begin
        bank[sel_in] <= ctrl_out;
        bank_q       <= bank[sel_out];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [23:0] w);
        host_we   = 1'b1;
        host_data = w;
        tick();
        host_we   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if ({host_ack, cmd_count, full, overflow, running, seq_done, timeout_err,
             ctrl_out, sel_in, sel_out, lcd_start} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_values: got ack=%0b cnt=%0d full=%0b ovf=%0b run=%0b done=%0b terr=%0b ctrl=%h sin=%0d sout=%0d start=%0b, expected all 0",
                     host_ack, cmd_count, full, overflow, running, seq_done, timeout_err,
                     ctrl_out, sel_in, sel_out, lcd_start);
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
        model_list.delete();
        model_ovf = 1'b0;
    endtask

    task automatic test_write_three();
        logic [23:0] words [3];
        words[0] = 24'h010203;
        words[1] = 24'h040506;
        words[2] = 24'h070809;
        for (int i = 0; i < 3; i++) begin
            host_write(words[i]);
            model_list.push_back(words[i]);
            checks++;
            if (host_ack !== 1'b1 || sel_in !== 5'(i) || ctrl_out !== words[i] ||
                cmd_count !== 6'(model_list.size())) begin
                errors++;
                $display("[TB] FAIL write_%0d: ack=%0b sel_in=%0d ctrl=%h cnt=%0d, expected 1/%0d/%h/%0d",
                         i, host_ack, sel_in, ctrl_out, cmd_count, i, words[i], model_list.size());
            end
            tick();
            checks++;
            if (host_ack !== 1'b0 || ctrl_out !== words[i]) begin
                errors++;
                $display("[TB] FAIL write_hold_%0d: ack=%0b ctrl=%h, expected 0/%h",
                         i, host_ack, ctrl_out, words[i]);
            end
        end
    endtask

    task automatic test_replay(input bit randomized);
        int n, starts, dones, next_start, done_at, seq_end, d;
        bit spur;
        n          = model_list.size();
        starts     = 0;
        dones      = 0;
        next_start = 3;
        done_at    = -1;
        seq_end    = -1;
        spur       = 1'b0;
        host_start = 1'b1;
        for (int cyc = 1; cyc <= 3000; cyc++) begin
            tick();
            host_start = 1'b0;
            host_we    = 1'b0;
            if (cyc == 1) begin
                checks++;
                if (running !== 1'b1 || timeout_err !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL replay_enter: running=%0b timeout_err=%0b, expected 1/0",
                             running, timeout_err);
                end
            end
            if (lcd_start === 1'b1) begin
                starts++;
                checks++;
                if (cyc != next_start) begin
                    errors++;
                    $display("[TB] FAIL strobe_time_%0d: at clock %0d, expected %0d",
                             starts, cyc, next_start);
                end
                checks++;
                if (starts > n || sel_out !== 5'(starts - 1) || bank_q !== model_list[starts - 1]) begin
                    errors++;
                    $display("[TB] FAIL strobe_data_%0d: sel_out=%0d word=%h, expected entry %0d of %0d",
                             starts, sel_out, bank_q, starts - 1, n);
                end
                d       = randomized ? int'($urandom_range(0, 6)) : 5;
                spur    = randomized && ($urandom_range(0, 1) == 1);
                done_at = cyc + d;
                if (starts < n) next_start = cyc + d + GAP + 4;
                else            seq_end    = cyc + d + GAP + 2;
            end
            lcd_done = (cyc == done_at) || (spur && cyc == done_at + 1);
            if (seq_done === 1'b1) begin
                dones++;
                checks++;
                if (cyc != seq_end || running !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL seq_done_time: at clock %0d running=%0b, expected clock %0d running=0",
                             cyc, running, seq_end);
                end
                break;
            end
            if (randomized && running) begin
                checks++;
                if (host_ack !== 1'b0 || cmd_count !== 6'(n) || overflow !== model_ovf) begin
                    errors++;
                    $display("[TB] FAIL write_while_running: ack=%0b cnt=%0d ovf=%0b, expected 0/%0d/%0b",
                             host_ack, cmd_count, overflow, n, model_ovf);
                end
                host_we   = ($urandom_range(0, 1) == 1);
                host_data = 24'($urandom);
            end
        end
        lcd_done = 1'b0;
        host_we  = 1'b0;
        checks++;
        if (starts != n || dones != 1) begin
            errors++;
            $display("[TB] FAIL replay_counts: strobes=%0d seq_done=%0d, expected %0d/1", starts, dones, n);
        end
        tick();
        checks++;
        if (seq_done !== 1'b0 || lcd_start !== 1'b0 || running !== 1'b0 || sel_out !== 5'(n - 1)) begin
            errors++;
            $display("[TB] FAIL replay_after: done=%0b start=%0b run=%0b sel_out=%0d, expected 0/0/0/%0d",
                     seq_done, lcd_start, running, sel_out, n - 1);
        end
    endtask

    task automatic test_timeout();
        int ls, sd, starts;
        ls = -1; sd = -1; starts = 0;
        lcd_done   = 1'b0;
        host_start = 1'b1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            tick();
            host_start = 1'b0;
            if (lcd_start === 1'b1) begin
                starts++;
                ls = cyc;
            end
            if (seq_done === 1'b1) begin
                sd = cyc;
                break;
            end
        end
        checks++;
        if (starts != 1 || ls != 3 || sd != ls + TO) begin
            errors++;
            $display("[TB] FAIL timeout_time: strobes=%0d strobe@%0d done@%0d, expected 1 strobe @3 done @%0d",
                     starts, ls, sd, 3 + TO);
        end
        checks++;
        if (timeout_err !== 1'b1 || running !== 1'b0 || sel_out !== 5'd0) begin
            errors++;
            $display("[TB] FAIL timeout_flags: terr=%0b run=%0b sel_out=%0d, expected 1/0/0",
                     timeout_err, running, sel_out);
        end
        tick();
        checks++;
        if (timeout_err !== 1'b1 || seq_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_sticky: terr=%0b done=%0b, expected 1/0", timeout_err, seq_done);
        end
    endtask

    task automatic test_full_overflow();
        logic [23:0] w;
        host_clear = 1'b1;
        tick();
        host_clear = 1'b0;
        model_list.delete();
        model_ovf = 1'b0;
        for (int i = 0; i < 33; i++) begin
            w = 24'($urandom);
            host_write(w);
            if (model_list.size() < 32) begin
                model_list.push_back(w);
                checks++;
                if (host_ack !== 1'b1 || cmd_count !== 6'(i + 1) || sel_in !== 5'(i) ||
                    ctrl_out !== w || full !== (i == 31) || overflow !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL fill_%0d: ack=%0b cnt=%0d sel_in=%0d ctrl=%h full=%0b ovf=%0b, expected 1/%0d/%0d/%h/%0b/0",
                             i, host_ack, cmd_count, sel_in, ctrl_out, full, overflow, i + 1, i, w, i == 31);
                end
            end else begin
                model_ovf = 1'b1;
                checks++;
                if (host_ack !== 1'b0 || cmd_count !== 6'd32 || full !== 1'b1 || overflow !== 1'b1 ||
                    sel_in !== 5'd31 || ctrl_out !== model_list[31]) begin
                    errors++;
                    $display("[TB] FAIL overflow_write: ack=%0b cnt=%0d full=%0b ovf=%0b sel_in=%0d ctrl=%h, expected 0/32/1/1/31/%h",
                             host_ack, cmd_count, full, overflow, sel_in, ctrl_out, model_list[31]);
                end
            end
        end
        tick();
    endtask

    task automatic test_clear();
        logic [23:0] last;
        last       = model_list[model_list.size() - 1];
        host_we    = 1'b1;
        host_clear = 1'b1;
        host_data  = 24'hABCDEF;
        tick();
        host_we    = 1'b0;
        host_clear = 1'b0;
        model_list.delete();
        model_ovf = 1'b0;
        checks++;
        if (cmd_count !== 6'd0 || overflow !== 1'b0 || full !== 1'b0 || host_ack !== 1'b0 ||
            ctrl_out !== last || sel_in !== 5'd31) begin
            errors++;
            $display("[TB] FAIL clear: cnt=%0d ovf=%0b full=%0b ack=%0b ctrl=%h sel_in=%0d, expected 0/0/0/0/%h/31",
                     cmd_count, overflow, full, host_ack, ctrl_out, sel_in, last);
        end
    endtask

    task automatic test_empty_start();
        int bad;
        bad = 0;
        host_start = 1'b1;
        tick();
        host_start = 1'b0;
        checks++;
        if (seq_done !== 1'b1 || running !== 1'b0 || lcd_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL empty_start: done=%0b run=%0b start=%0b, expected 1/0/0",
                     seq_done, running, lcd_start);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (seq_done !== 1'b0 || lcd_start !== 1'b0 || running !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL empty_after: %0d bad cycles, expected 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        int found, bad;
        found = 0;
        bad   = 0;
        host_write(24'h111111);
        host_write(24'h222222);
        host_start = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            tick();
            host_start = 1'b0;
            if (lcd_start === 1'b1) begin
                found = 1;
                break;
            end
        end
        tick();
        checks++;
        if (found != 1 || running !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_mid_setup: strobe_seen=%0d run=%0b, expected 1/1", found, running);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({host_ack, cmd_count, full, overflow, running, seq_done, timeout_err,
             ctrl_out, sel_in, sel_out, lcd_start} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid_values: cnt=%0d run=%0b ctrl=%h sin=%0d sout=%0d, expected all 0",
                     cmd_count, running, ctrl_out, sel_in, sel_out);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (lcd_start !== 1'b0 || seq_done !== 1'b0 || running !== 1'b0) bad++;
        end
        @(negedge clk);
        reset = 1'b0;
        lcd_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (lcd_start !== 1'b0 || seq_done !== 1'b0 || running !== 1'b0) bad++;
        end
        lcd_done = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL reset_mid_quiet: %0d bad cycles, expected 0", bad);
        end
        model_list.delete();
        model_ovf = 1'b0;
        host_write(24'h5A5A5A);
        model_list.push_back(24'h5A5A5A);
        checks++;
        if (host_ack !== 1'b1 || sel_in !== 5'd0 || cmd_count !== 6'd1 || ctrl_out !== 24'h5A5A5A) begin
            errors++;
            $display("[TB] FAIL reset_mid_write: ack=%0b sel_in=%0d cnt=%0d ctrl=%h, expected 1/0/1/5a5a5a",
                     host_ack, sel_in, cmd_count, ctrl_out);
        end
    endtask

    initial begin
        host_we    = 1'b0;
        host_data  = 24'd0;
        host_clear = 1'b0;
        host_start = 1'b0;
        lcd_done   = 1'b0;
        model_ovf  = 1'b0;
        test_reset();
        test_write_three();
        test_replay(1'b0);
        test_timeout();
        test_replay(1'b1);
        test_full_overflow();
        test_replay(1'b1);
        test_clear();
        test_empty_start();
        test_reset_mid();
        test_replay(1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_cmd_seq.md
Name: lcd_cmd_seq

Overview:
- Controller for the 32-entry LCD command register bank.
- Owns the bank's write-pointer side (sel_in plus a held 24-bit command word) and its read-pointer side (sel_out).
- Replays the stored command list to the LCD interface engine one entry at a time, using a strobe/done handshake, an inter-command gap and a per-command timeout.
- Sits between the Wishbone LCD slave registers and the register bank/LCD engine.

Parameters:
- GAP_CYCLES, 50, idle clocks inserted after each completed command (0 = none).
- TIMEOUT_CYCLES, 65535, maximum clocks to wait for lcd_done before aborting (16-bit counter).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- host_we  in  1  one-cycle request to append host_data to the command list.
- host_data  in  24  command word {addr[23:16], ctrl[15:8], data[7:0]}.
- host_clear  in  1  one-cycle request to empty the list (ignored while running).
- host_start  in  1  one-cycle request to replay entries 0..cmd_count-1.
- host_ack  out  1  one-cycle pulse: the write was accepted.
- cmd_count  out  6  number of stored commands, 0..32.
- full  out  1  cmd_count == 32.
- overflow  out  1  sticky: a write was dropped; cleared by host_clear or reset.
- running  out  1  sequencer is not in IDLE.
- seq_done  out  1  one-cycle pulse: sequence finished or aborted.
- timeout_err  out  1  sticky: the last sequence aborted on timeout; cleared at next host_start.
- ctrl_out  out  24  command word driven to the bank's ctrl_in.
- sel_in  out  5  bank write index.
- sel_out  out  5  bank read index.
- lcd_start  out  1  one-cycle strobe to the LCD engine: the bank outputs are valid.
- lcd_done  in  1  one-cycle pulse from the LCD engine: the command has completed.

Behaviour:
- Reset values: every output and every internal counter is 0; state is IDLE.
- Write side (bank rewrites the sel_in entry on every clock, so ctrl_out and sel_in change together and hold between writes):
  - Write is accepted when host_we && state==IDLE && !full. Then, at the next edge: ctrl_out<=host_data, sel_in<=cmd_count[4:0], cmd_count++, host_ack=1.
  - host_we while full: dropped, overflow<=1, no ack.
  - host_we while running: dropped silently, no ack, overflow unchanged.
  - host_clear in IDLE: cmd_count<=0, overflow<=0. sel_in and ctrl_out hold, so the last entry keeps its value.
  - host_we and host_clear in the same cycle: clear wins and the write is dropped.
- Sequencer FSM, with idx as a 6-bit counter:
  - IDLE: on host_start, timeout_err<=0.
    - cmd_count==0: pulse seq_done next cycle, stay in IDLE.
    - Otherwise: idx<=0, sel_out<=0, go to LOAD.
  - LOAD (one cycle; the bank registers its outputs one clock after sel_out changes): go to STROBE.
  - STROBE: lcd_start=1 for exactly one cycle; clear the timeout counter; go to WAIT.
  - WAIT: count clocks.
    - lcd_done: idx++, go to GAP. If GAP_CYCLES==0, go directly to NEXT.
    - Counter reaches TIMEOUT_CYCLES-1 without lcd_done: timeout_err<=1, seq_done pulse, go to IDLE.
  - GAP: count GAP_CYCLES clocks, then go to NEXT.
  - NEXT:
    - idx==cmd_count: seq_done pulse, go to IDLE.
    - Otherwise: sel_out<=idx[4:0], go to LOAD.
- Latency: host_start to first lcd_start = 3 clocks.
- lcd_done outside WAIT is ignored.
- host_start while running is ignored.
- running = (state != IDLE).
- sel_out holds its last value when the FSM returns to IDLE.
- cmd_count==32: idx reaches 32 and sel_out wraps only internally; index 31 is the last entry read.
- Asynchronous reset mid-sequence: immediate return to IDLE with all outputs at 0. No lcd_start is issued and no seq_done pulse is generated.

Test Plan:
- Write 3 words (0x010203, 0x040506, 0x070809) -> 3 host_ack pulses; sel_in goes 0,1,2; ctrl_out tracks each word; cmd_count=3.
- host_start with 3 entries, lcd_done returned 5 clocks after each lcd_start, GAP_CYCLES=2 -> sel_out steps 0,1,2; exactly 3 lcd_start pulses, each 1 clock after its LOAD; one seq_done; running deasserts.
- Write 33 words -> cmd_count=32, full=1, 33rd write unacked, overflow=1; then host_clear -> cmd_count=0, overflow=0.
- host_start, then lcd_done withheld with TIMEOUT_CYCLES=16 -> timeout_err=1 and seq_done 16 clocks after lcd_start; next host_start clears timeout_err.
- host_start with cmd_count=0 -> seq_done the next cycle, no lcd_start; host_we during a run -> no ack and cmd_count unchanged.
- Assert reset during WAIT -> all outputs 0 immediately, FSM IDLE; a subsequent write lands in entry 0.
